board_led_ctrl: RTL and testbench

//  Parametrised Avalon-MM LED controller, successor to the fixed 4-bit board LED PIO.

---
 rtl/board_led_ctrl.sv | 131 +++++++++++++
 tb/tb_board_led_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/board_led_ctrl.sv
// Avalon-MM LED controller: N_LEDS channels, each static, blink (prescaled phase) or PWM-dimmed.
// Optional SET/CLR bit registers at addresses 4/5 when BOARD_LED_CTRL_BITSET_EN is defined.
module board_led_ctrl #(
  parameter int unsigned        N_LEDS      = 4,
  parameter int unsigned        CNT_W       = 24,
  parameter logic [N_LEDS-1:0]  RESET_VALUE = '0,
  parameter bit                 ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [N_LEDS-1:0] out_port
);

  localparam int unsigned MODE_W = 2 * N_LEDS;
  localparam int unsigned PWM_W  = 8;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_MODE = 3'd1;
  localparam logic [2:0] ADDR_DIV  = 3'd2;
  localparam logic [2:0] ADDR_DUTY = 3'd3;
`ifdef BOARD_LED_CTRL_BITSET_EN
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;
`endif

  localparam logic [1:0] MODE_BLINK = 2'b01;
  localparam logic [1:0] MODE_PWM   = 2'b10;

  generate
    if (N_LEDS < 1 || N_LEDS > 16) begin : g_bad_n_leds
      $error("board_led_ctrl: N_LEDS must be in 1..16");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
      $error("board_led_ctrl: CNT_W must be in 1..32");
    end
  endgenerate

  logic [N_LEDS-1:0] data_q, data_nxt;
  logic [MODE_W-1:0] mode_q;
  logic [CNT_W-1:0]  div_q;
  logic [PWM_W-1:0]  duty_q;
  logic [CNT_W-1:0]  presc_q;
  logic              phase_q;
  logic [PWM_W-1:0]  pwm_cnt_q;
  logic              pwm_on;
  logic [N_LEDS-1:0] lit;
  logic              wr;
  logic              unused_wd;

  assign wr        = chipselect & ~write_n;
  assign pwm_on    = (pwm_cnt_q < duty_q);
  assign unused_wd = ^writedata;

  // DATA next value, including the optional write-1-to-set / write-1-to-clear aliases
  always_comb begin
    data_nxt = data_q;
    if (wr && address == ADDR_DATA) data_nxt = writedata[N_LEDS-1:0];
`ifdef BOARD_LED_CTRL_BITSET_EN
    if (wr && address == ADDR_SET)  data_nxt = data_q | writedata[N_LEDS-1:0];
    if (wr && address == ADDR_CLR)  data_nxt = data_q & ~writedata[N_LEDS-1:0];
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      mode_q <= '0;
      div_q  <= '0;
      duty_q <= '0;
    end else begin
      data_q <= data_nxt;
      if (wr && address == ADDR_MODE) mode_q <= writedata[MODE_W-1:0];
      if (wr && address == ADDR_DIV)  div_q  <= writedata[CNT_W-1:0];
      if (wr && address == ADDR_DUTY) duty_q <= writedata[PWM_W-1:0];
    end
  end

  // Blink prescaler; >= keeps the count bounded when the terminal count shrinks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      phase_q <= 1'b0;
    end else if (wr && address == ADDR_DIV) begin
      presc_q <= '0;
    end else if (presc_q >= div_q) begin
      presc_q <= '0;
      phase_q <= ~phase_q;
    end else begin
      presc_q <= presc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_cnt_q <= '0;
    else          pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
  end

  // Per-channel lit level; reserved mode 11 falls back to static
  always_comb begin
    lit = '0;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      case (mode_q[2*i +: 2])
        MODE_BLINK: lit[i] = data_q[i] & phase_q;
        MODE_PWM:   lit[i] = data_q[i] & pwm_on;
        default:    lit[i] = data_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= RESET_VALUE ^ {N_LEDS{ACTIVE_LOW}};
    else          out_port <= lit ^ {N_LEDS{ACTIVE_LOW}};
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(data_q);
      ADDR_MODE: readdata = 32'(mode_q);
      ADDR_DIV:  readdata = 32'(div_q);
      ADDR_DUTY: readdata = 32'(duty_q);
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_board_led_ctrl.sv
// Scoreboard bench for board_led_ctrl: a 4-LED active-low instance and a 16-LED active-high one.
module tb_board_led_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs4, cs16, write_n;
  logic [31:0] writedata;
  logic [31:0] rd4, rd16;
  logic [3:0]  out4;
  logic [15:0] out16;

  always #5 clk = ~clk;

`ifdef BOARD_LED_CTRL_BITSET_EN
  localparam bit BITSET = 1'b1;
`else
  localparam bit BITSET = 1'b0;
`endif

  board_led_ctrl u4 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs4),
    .write_n(write_n), .writedata(writedata), .readdata(rd4), .out_port(out4)
  );

  board_led_ctrl #(.N_LEDS(16), .CNT_W(8), .RESET_VALUE(16'hA5A5), .ACTIVE_LOW(1'b0)) u16 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs16),
    .write_n(write_n), .writedata(writedata), .readdata(rd16), .out_port(out16)
  );

  typedef enum int {K_OUT4, K_OUT16, K_RD4, K_RD16, K_CNT} kind_t;
  typedef struct {
    kind_t       kind;
    string       name;
    logic [31:0] exp;
    logic [31:0] act;
  } chk_t;

  chk_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic expect_v(input kind_t k, input string n, input logic [31:0] e,
                          input logic [31:0] a = '0);
    chk_t c;
    c.kind = k; c.name = n; c.exp = e; c.act = a;
    sbq.push_back(c);
  endtask

  // Monitor: pops every pending expectation on the falling edge
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      chk_t        c;
      logic [31:0] got;
      c = sbq.pop_front();
      case (c.kind)
        K_OUT4:  got = 32'(out4);
        K_OUT16: got = 32'(out16);
        K_RD4:   got = rd4;
        K_RD16:  got = rd16;
        default: got = c.act;
      endcase
      checks++;
      if (got !== c.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, got, c.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit big, input logic [2:0] a, input logic [31:0] d);
    cs4 = ~big; cs16 = big; address = a; writedata = d; write_n = 1'b0;
    @(posedge clk);
    #1;
    cs4 = 1'b0; cs16 = 1'b0; write_n = 1'b1;
  endtask

  task automatic pwm_count(input string n, input int e);
    int lows = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (out4[0] == 1'b0) lows++;
    end
    expect_v(K_CNT, n, 32'(e), 32'(lows));
  endtask

  initial begin
    reset_n = 1'b0; address = '0; cs4 = 1'b0; cs16 = 1'b0; write_n = 1'b1; writedata = '0;

    // T1: reset state, then first write latency
    step(); step();
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      expect_v(K_RD4, "rst_rd4", 32'h0);
      expect_v(K_RD16, "rst_rd16", (a == 0) ? 32'h0000A5A5 : 32'h0);
      step();
    end
    expect_v(K_OUT4, "rst_out4", 32'hF);
    expect_v(K_OUT16, "rst_out16", 32'hA5A5);
    step();
    reset_n = 1'b1;
    wr(1'b0, 3'd0, 32'h5);
    expect_v(K_OUT4, "t1_out_at_e", 32'hF);
    step();
    address = 3'd0;
    expect_v(K_OUT4, "t1_out_e1", 32'hA);
    expect_v(K_RD4, "t1_rd_data", 32'h5);
    step();

    // T2: blink with BLINK_DIV=3, then rewrite to 1 mid-count
    step(); reset_n = 1'b0; step(); reset_n = 1'b1;
    wr(1'b0, 3'd2, 32'h3);
    wr(1'b0, 3'd0, 32'hF);
    wr(1'b0, 3'd1, 32'h55);
    for (int k = 4; k <= 15; k++) begin
      step();
      expect_v(K_OUT4, "t2_blink4", (k < 6) ? 32'hF : ((((k - 6) / 4) % 2) == 0 ? 32'h0 : 32'hF));
    end
    wr(1'b0, 3'd2, 32'h1);
    for (int k = 17; k <= 25; k++) begin
      step();
      expect_v(K_OUT4, "t2_blink2", (k < 19) ? 32'h0 : ((((k - 19) / 2) % 2) == 0 ? 32'hF : 32'h0));
    end

    // T6: asynchronous reset pulse between edges while an LED is lit
    step();
    #1 reset_n = 1'b0;
    expect_v(K_OUT4, "t6_async_out", 32'hF);
    @(negedge clk);
    #1 reset_n = 1'b1;
    wr(1'b0, 3'd0, 32'hF);
    wr(1'b0, 3'd1, 32'h55);
    for (int k = 3; k <= 10; k++) begin
      step();
      expect_v(K_OUT4, "t6_restart", (k % 2 == 1) ? 32'hF : 32'h0);
    end

    // T3: PWM duty on LED 0
    wr(1'b0, 3'd0, 32'h1);
    wr(1'b0, 3'd1, 32'h2);
    wr(1'b0, 3'd3, 32'd64);
    pwm_count("t3_duty64_lows", 64);
    wr(1'b0, 3'd3, 32'd0);
    pwm_count("t3_duty0_lows", 0);
    wr(1'b0, 3'd3, 32'd255);
    pwm_count("t3_duty255_lows", 255);
    address = 3'd3;
    expect_v(K_RD4, "t3_rd_duty", 32'd255);
    step();

    // T5: SET / CLR aliases (inert without the macro)
    wr(1'b0, 3'd0, 32'h3);
    wr(1'b0, 3'd4, 32'h4);
    address = 3'd0;
    expect_v(K_RD4, "t5_after_set", BITSET ? 32'h7 : 32'h3);
    step();
    wr(1'b0, 3'd5, 32'h1);
    address = 3'd0;
    expect_v(K_RD4, "t5_after_clr", BITSET ? 32'h6 : 32'h3);
    step();
    address = 3'd4; expect_v(K_RD4, "t5_rd_set", 32'h0); step();
    address = 3'd5; expect_v(K_RD4, "t5_rd_clr", 32'h0); step();

    // T4: 16-LED width, unmapped address, reserved mode
    wr(1'b1, 3'd0, 32'hFFFF_FFFF);
    address = 3'd0; expect_v(K_RD16, "t4_rd_data", 32'h0000FFFF); step();
    wr(1'b1, 3'd7, 32'h1234_5678);
    address = 3'd7; expect_v(K_RD16, "t4_rd_addr7", 32'h0); step();
    address = 3'd0; expect_v(K_RD16, "t4_data_kept", 32'h0000FFFF); step();
    address = 3'd1; expect_v(K_RD16, "t4_mode_kept", 32'h0); step();
    address = 3'd3; expect_v(K_RD16, "t4_duty_kept", 32'h0); step();
    wr(1'b1, 3'd1, 32'hFFFF_FFFF);
    address = 3'd1; expect_v(K_RD16, "t4_rd_mode", 32'hFFFF_FFFF); step();
    wr(1'b1, 3'd2, 32'hFFFF_FFFF);
    address = 3'd2; expect_v(K_RD16, "t4_rd_div", 32'h0000_00FF); step();
    for (int k = 0; k < 4; k++) begin
      expect_v(K_OUT16, "t4_reserved_static", 32'h0000FFFF);
      step();
    end

    step();
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
